// File: rtl/afifo_rd_unpack_64to16_pkg.sv
// Shared constants and lane selection for the 64-to-16 read-side unpacker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package afifo_rd_unpack_64to16_pkg;

  localparam int FIFO_DATA_W_DFLT = 64;
  localparam int OUT_W_DFLT       = 16;
  localparam int RATIO            = FIFO_DATA_W_DFLT / OUT_W_DFLT;
  localparam int LANE_W           = $clog2(RATIO);
  // Word buffer depth (head + spare); also the total read credit.
  localparam int BUF_DEPTH        = 2;
  localparam int LVL_W            = $clog2(BUF_DEPTH + 1);
  localparam int CRED_W           = LVL_W + 1;

  // Pick beat 'lane' from a FIFO word; lane 0 is the low slice when
  // lsb_first is set, otherwise the high slice.
  function automatic logic [OUT_W_DFLT-1:0] lane_sel(
    input logic [FIFO_DATA_W_DFLT-1:0] word,
    input logic [LANE_W-1:0]           lane,
    input logic                        lsb_first
  );
    logic [LANE_W-1:0] idx;
    idx = lsb_first ? lane : (LANE_W'(RATIO - 1) - lane);
    return word[idx*OUT_W_DFLT +: OUT_W_DFLT];
  endfunction

endpackage

// File: rtl/afifo_rd_fetch_tracker.sv
// Issues FIFO reads against a fixed credit of BUF_DEPTH words and tracks them through the read latency.
// Latency: o_capture asserts RD_LATENCY cycles after the cycle o_fifo_rd_en was high.
// Backpressure: no read is issued while buffered + in-flight words reach BUF_DEPTH or the FIFO is empty.
module afifo_rd_fetch_tracker
  import afifo_rd_unpack_64to16_pkg::*;
#(
  parameter int RD_LATENCY = 1  // 1 or 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fifo_rd_empty,
  input  logic [LVL_W-1:0] i_buf_level,
  output logic             o_fifo_rd_en,
  output logic             o_capture
);

  logic [RD_LATENCY-1:0] r_pipe;
  logic [LVL_W-1:0]      w_inflight_cnt;
  logic [CRED_W-1:0]     w_credit_used;

  // Count reads issued but whose data has not yet been captured.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + LVL_W'(r_pipe[i]);
    end
  end

  assign w_credit_used = {1'b0, i_buf_level} + {1'b0, w_inflight_cnt};
  // Reset gating keeps the FIFO untouched while the block is held in reset.
  assign o_fifo_rd_en  = !i_rst && !i_fifo_rd_empty && (w_credit_used < CRED_W'(BUF_DEPTH));
  assign o_capture     = r_pipe[RD_LATENCY-1];

  // Shift the read-valid marker along with the FIFO's read pipeline.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= o_fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

endmodule

// File: rtl/afifo_rd_unpack_64to16.sv
// Reads 64-bit words from the async FIFO and replays them as four 16-bit beats on a valid/ready stream.
// Latency: first beat RD_LATENCY+1 cycles after the read; then one beat per cycle.
// Backpressure: m_ready low freezes the beat; reads stop once two words are held or in flight.
module afifo_rd_unpack_64to16
  import afifo_rd_unpack_64to16_pkg::*;
#(
  parameter int FIFO_DATA_W = FIFO_DATA_W_DFLT,  // must equal OUT_W*RATIO
  parameter int OUT_W       = OUT_W_DFLT,
  parameter int RD_LATENCY  = 1,                 // 2 when the FIFO has an output register
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  output logic                   fifo_rd_en,
  input  logic [FIFO_DATA_W-1:0] fifo_rd_data,
  input  logic                   fifo_rd_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_last,
  output logic [1:0]             buf_level
);

  logic [FIFO_DATA_W-1:0] r_buf [BUF_DEPTH];
  logic                   r_head;
  logic [LVL_W-1:0]       r_level;
  logic [LANE_W-1:0]      r_lane;

  logic w_capture;
  logic w_fire;
  logic w_pop;
  logic w_wr_idx;
  logic w_lane_end;

  afifo_rd_fetch_tracker #(
    .RD_LATENCY(RD_LATENCY)
  ) u_fetch (
    .i_clk          (rd_clk),
    .i_rst          (rd_rst),
    .i_fifo_rd_empty(fifo_rd_empty),
    .i_buf_level    (r_level),
    .o_fifo_rd_en   (fifo_rd_en),
    .o_capture      (w_capture)
  );

  assign w_lane_end = (r_lane == LANE_W'(RATIO - 1));
  assign w_fire     = m_valid && m_ready;
  assign w_pop      = w_fire && w_lane_end;
  // Credit guarantees at most one word is held when a capture lands, so the
  // free slot is always head ^ level[0]; on a same-cycle pop it becomes the new head.
  assign w_wr_idx   = r_head ^ r_level[0];

  assign m_valid   = (r_level != '0);
  assign m_data    = lane_sel(r_buf[r_head], r_lane, LSB_FIRST);
  assign m_last    = m_valid && w_lane_end;
  assign buf_level = r_level;

  // Write returning FIFO data into the free buffer slot.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      r_buf[w_wr_idx] <= fifo_rd_data;
    end
  end

  // Advance the lane on each accepted beat; retire the head word after its last lane.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_head  <= 1'b0;
      r_level <= '0;
      r_lane  <= '0;
    end else begin
      if (w_fire) begin
        r_lane <= r_lane + LANE_W'(1);
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_capture, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
